// File: rtl/alu_cmd_issuer_pkg.sv
// Shared definitions for the ALU command issuer: opcode values, FSM states,
// response flag bit positions and the packed command word stored in the FIFO.
package alu_issuer_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_SHL  = 4'h7;
   localparam logic [3:0] OP_SHR  = 4'h8;
   localparam logic [3:0] OP_XNOR = 4'h9;
   localparam logic [3:0] OP_NOT  = 4'hA;
   localparam logic [3:0] OP_MAX  = 4'hA;

   localparam int FLG_C = 3;
   localparam int FLG_V = 2;
   localparam int FLG_Z = 1;
   localparam int FLG_N = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] b;
      logic [7:0] a;
   } cmd_t;

   // Opcodes above OP_MAX have no ALU function behind them.
   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_MAX;
   endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Bundle of the issuer's command, ALU and response signals.
// master: the command source / ALU side; slave: the issuer itself.
interface alu_cmd_issuer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic [3:0] cmd_op;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_select;
   logic [7:0] alu_result;
   logic       alu_carry;
   logic       alu_overflow;
   logic       alu_zero;
   logic       alu_negative;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_result;
   logic [3:0] rsp_flags;
   logic       rsp_err;
   logic       busy;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op,
      output alu_result, alu_carry, alu_overflow, alu_zero, alu_negative,
      output rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_select,
      input  rsp_valid, rsp_result, rsp_flags, rsp_err, busy
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op,
      input  alu_result, alu_carry, alu_overflow, alu_zero, alu_negative,
      input  rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_select,
      output rsp_valid, rsp_result, rsp_flags, rsp_err, busy
   );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries of WIDTH bits, pointers carry an extra wrap bit
// so full and empty fall straight out of a pointer compare.
module alu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // Pointer update; a reset empties the FIFO without touching storage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Entry storage, written at the tail on an accepted push.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/alu_cmd_issuer.sv
// Requester-side front end for the 8-bit ALU: queues commands, issues them one
// at a time on registered operand/select lines, samples the ALU after ALU_LAT
// cycles and hands result and flags back on a valid/ready response channel.
// Optional opcode checking is compiled in with ALU_CMD_ISSUER_OPCHK_EN.
module alu_cmd_issuer
   import alu_issuer_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   alu_cmd_issuer_if.slave bus
);
   localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] wait_cnt;
   cmd_t          push_cmd;
   cmd_t          head_cmd;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          head_bad;
   logic          issue_ok;
   logic          issue_bad;
   logic          capture;
   logic          rsp_done;
   logic [7:0]    a_q;
   logic [7:0]    b_q;
   logic [3:0]    sel_q;
   logic          rsp_valid_q;
   logic [7:0]    rsp_result_q;
   logic [3:0]    rsp_flags_q;
   logic          rsp_err_q;

   assign bus.cmd_ready = reset_n & ~fifo_full;
   assign push          = bus.cmd_valid & bus.cmd_ready;
   assign push_cmd      = {bus.cmd_op, bus.cmd_b, bus.cmd_a};
   assign rsp_done      = rsp_valid_q & bus.rsp_ready;

`ifdef ALU_CMD_ISSUER_OPCHK_EN
   assign head_bad = !op_legal(head_cmd.op);
`else
   assign head_bad = 1'b0;
`endif

   alu_cmd_fifo #(.DEPTH(DEPTH), .WIDTH($bits(cmd_t))) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_cmd),
      .pop       (pop),
      .pop_data  (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Next state: a new command issues from IDLE or straight out of a completed response.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      issue_ok   = 1'b0;
      issue_bad  = 1'b0;
      capture    = 1'b0;
      if (!fifo_empty && (state == ST_IDLE || (state == ST_RESP && rsp_done))) begin
         pop = 1'b1;
         if (head_bad) begin
            issue_bad  = 1'b1;
            state_next = ST_RESP;
         end else begin
            issue_ok   = 1'b1;
            state_next = ST_EXEC;
         end
      end else begin
         case (state)
            ST_EXEC: begin
               if (wait_cnt == CW'(ALU_LAT - 1)) begin
                  capture    = 1'b1;
                  state_next = ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_done) state_next = ST_IDLE;
            end
            default: state_next = state;
         endcase
      end
   end

   // Operand registers, wait counter and response holding registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q          <= '0;
         b_q          <= '0;
         sel_q        <= '0;
         wait_cnt     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         if (issue_ok) begin
            a_q      <= head_cmd.a;
            b_q      <= head_cmd.b;
            sel_q    <= head_cmd.op;
            wait_cnt <= '0;
         end else if (state == ST_EXEC) begin
            wait_cnt <= wait_cnt + CW'(1);
         end
         if (capture) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= bus.alu_result;
            rsp_flags_q  <= {bus.alu_carry, bus.alu_overflow, bus.alu_zero, bus.alu_negative};
            rsp_err_q    <= 1'b0;
         end else if (issue_bad) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b1;
         end else if (rsp_done) begin
            rsp_valid_q  <= 1'b0;
         end
      end
   end

   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_select = sel_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.busy       = !fifo_empty || (state != ST_IDLE);
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: one instance with ALU_LAT=1 driven by a
// behavioural ALU, one with ALU_LAT=3 whose ALU outputs are scripted per cycle.
// Expectations for opcode 4'hC follow ALU_CMD_ISSUER_OPCHK_EN.
module tb_alu_cmd_issuer;
   import alu_issuer_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] last_op = 4'h0;

   alu_cmd_issuer_if bus1 ();
   alu_cmd_issuer_if bus3 ();

   alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus1)
   );

   alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(3)) dut3 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus3)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Behavioural 8-bit ALU: returns {carry, overflow, zero, negative, result}.
   function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0]  wide;
      logic [15:0] prod;
      logic [7:0]  r;
      logic        c;
      logic        v;
      wide = '0;
      prod = '0;
      r    = '0;
      c    = 1'b0;
      v    = 1'b0;
      case (op)
         OP_ADD: begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[7:0];
            c    = wide[8];
            v    = (a[7] == b[7]) && (r[7] != a[7]);
         end
         OP_SUB: begin
            r = a - b;
            c = (a < b);
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         OP_MUL: begin
            prod = a * b;
            r    = prod[7:0];
            c    = |prod[15:8];
         end
         OP_DIV:  r = (b != 8'h00) ? a / b : 8'h00;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_SHL:  begin r = {a[6:0], 1'b0}; c = a[7]; end
         OP_SHR:  begin r = {1'b0, a[7:1]}; c = a[0]; end
         OP_XNOR: r = ~(a ^ b);
         OP_NOT:  r = ~a;
         default: r = 8'h00;
      endcase
      return {c, v, (r == 8'h00), r[7], r};
   endfunction

   // ALU attached to the single-cycle instance.
   always_comb begin
      {bus1.alu_carry, bus1.alu_overflow, bus1.alu_zero, bus1.alu_negative, bus1.alu_result} =
         alu_model(bus1.alu_select, bus1.alu_a, bus1.alu_b);
   end

   task automatic test_reset();
      #1;
      vectors++;
      if (bus1.cmd_ready !== 1'b0 || bus1.rsp_valid !== 1'b0 || bus1.busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl: got ready/valid/busy %b%b%b expected 000", bus1.cmd_ready, bus1.rsp_valid, bus1.busy);
      end
      vectors++;
      if ({bus1.alu_a, bus1.alu_b, bus1.alu_select} !== 20'h0 || {bus1.rsp_result, bus1.rsp_flags, bus1.rsp_err} !== 13'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_data: got alu %h rsp %h expected 0", {bus1.alu_a, bus1.alu_b, bus1.alu_select}, {bus1.rsp_result, bus1.rsp_flags, bus1.rsp_err});
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      vectors++;
      if (bus1.cmd_ready !== 1'b1 || bus1.busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_release: got ready/busy %b%b expected 10", bus1.cmd_ready, bus1.busy);
      end
   endtask

   task automatic test_single(input string name, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] exp_res, input logic [3:0] exp_flags);
      @(negedge clk);
      bus1.cmd_valid = 1'b1;
      bus1.cmd_op    = op;
      bus1.cmd_a     = a;
      bus1.cmd_b     = b;
      vectors++;
      if (bus1.cmd_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL %s cmd_ready: got %b expected 1", name, bus1.cmd_ready);
      end
      @(posedge clk);
      #1 bus1.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (bus1.rsp_valid !== 1'b0 || {bus1.alu_select, bus1.alu_a, bus1.alu_b} !== {op, a, b}) begin
         miscompares++;
         $display("[TB] FAIL %s issue: got valid %b alu %h expected 0 %h", name, bus1.rsp_valid, {bus1.alu_select, bus1.alu_a, bus1.alu_b}, {op, a, b});
      end
      @(negedge clk);
      vectors++;
      if (bus1.rsp_valid !== 1'b1 || bus1.rsp_result !== exp_res || bus1.rsp_flags !== exp_flags || bus1.rsp_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL %s response: got v%b r%h f%b e%b expected v1 r%h f%b e0", name, bus1.rsp_valid, bus1.rsp_result, bus1.rsp_flags, bus1.rsp_err, exp_res, exp_flags);
      end
      bus1.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus1.rsp_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus1.rsp_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.alu_a !== a || bus1.alu_select !== op) begin
         miscompares++;
         $display("[TB] FAIL %s complete: got v%b busy%b a%h sel%h expected v0 busy0 a%h sel%h", name, bus1.rsp_valid, bus1.busy, bus1.alu_a, bus1.alu_select, a, op);
      end
      last_op = op;
   endtask

   task automatic test_illegal_op();
      logic [3:0] exp_sel;
      logic [7:0] exp_res;
      logic [3:0] exp_flags;
      logic       exp_err;
      bit         seen;
`ifdef ALU_CMD_ISSUER_OPCHK_EN
      exp_sel   = last_op;
      exp_res   = 8'h00;
      exp_flags = 4'b0000;
      exp_err   = 1'b1;
`else
      exp_sel   = 4'hC;
      exp_res   = 8'h00;
      exp_flags = 4'b0010;
      exp_err   = 1'b0;
`endif
      seen = 1'b0;
      @(negedge clk);
      bus1.cmd_valid = 1'b1;
      bus1.cmd_op    = 4'hC;
      bus1.cmd_a     = 8'h12;
      bus1.cmd_b     = 8'h34;
      @(posedge clk);
      #1 bus1.cmd_valid = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
         @(negedge clk);
         if (bus1.rsp_valid === 1'b1) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("[TB] FAIL illegal_timeout: got no rsp_valid expected response within 8 cycles");
      end
      vectors++;
      if (bus1.rsp_result !== exp_res || bus1.rsp_flags !== exp_flags || bus1.rsp_err !== exp_err || bus1.alu_select !== exp_sel) begin
         miscompares++;
         $display("[TB] FAIL illegal_op: got r%h f%b e%b sel%h expected r%h f%b e%b sel%h", bus1.rsp_result, bus1.rsp_flags, bus1.rsp_err, bus1.alu_select, exp_res, exp_flags, exp_err, exp_sel);
      end
      bus1.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus1.rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [3:0] ops  [5] = '{OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_OR};
      logic [7:0] as   [5] = '{8'h01, 8'h03, 8'hF0, 8'hAA, 8'h80};
      logic [7:0] bs   [5] = '{8'h02, 8'h05, 8'h3C, 8'hAA, 8'h01};
      logic [7:0] ress [5] = '{8'h03, 8'hFE, 8'h30, 8'h00, 8'h81};
      logic [3:0] flgs [5] = '{4'b0000, 4'b1001, 4'b0000, 4'b0010, 4'b0001};
      int acc;
      int got;
      int last_cyc;
      int idx;
      logic rdy;
      acc = 0;
      bus1.rsp_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         idx = (acc < 5) ? acc : 4;
         bus1.cmd_valid = 1'b1;
         bus1.cmd_op    = ops[idx];
         bus1.cmd_a     = as[idx];
         bus1.cmd_b     = bs[idx];
         rdy = bus1.cmd_ready;
         @(posedge clk);
         if (rdy) acc++;
      end
      #1 bus1.cmd_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (acc != 5 || bus1.cmd_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL bp_accept: got %0d accepted ready %b expected 5 ready 0", acc, bus1.cmd_ready);
      end
      got = 0;
      last_cyc = -1;
      bus1.rsp_ready = 1'b1;
      for (int c = 0; c < 30 && got < 5; c++) begin
         if (c > 0) @(negedge clk);
         if (bus1.rsp_valid === 1'b1) begin
            vectors++;
            if (bus1.rsp_result !== ress[got] || bus1.rsp_flags !== flgs[got]) begin
               miscompares++;
               $display("[TB] FAIL bp_order[%0d]: got r%h f%b expected r%h f%b", got, bus1.rsp_result, bus1.rsp_flags, ress[got], flgs[got]);
            end
            if (got > 0) begin
               vectors++;
               if (c - last_cyc != 2) begin
                  miscompares++;
                  $display("[TB] FAIL bp_spacing[%0d]: got %0d cycles expected 2", got, c - last_cyc);
               end
            end
            last_cyc = c;
            got++;
         end
      end
      @(negedge clk);
      vectors++;
      if (got != 5 || bus1.busy !== 1'b0 || bus1.rsp_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL bp_drain: got %0d responses busy %b expected 5 busy 0", got, bus1.busy);
      end
      bus1.rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int acc;
      int stale;
      logic rdy;
      acc = 0;
      stale = 0;
      bus1.rsp_ready = 1'b0;
      for (int c = 0; c < 10 && acc < 4; c++) begin
         @(negedge clk);
         bus1.cmd_valid = 1'b1;
         bus1.cmd_op    = OP_ADD;
         bus1.cmd_a     = 8'(acc + 8'h40);
         bus1.cmd_b     = 8'h01;
         rdy = bus1.cmd_ready;
         @(posedge clk);
         if (rdy) acc++;
      end
      #1 bus1.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (acc != 4 || bus1.rsp_valid !== 1'b1 || bus1.busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL midrst_setup: got acc %0d valid %b busy %b expected 4 1 1", acc, bus1.rsp_valid, bus1.busy);
      end
      reset_n = 1'b0;
      #1;
      vectors++;
      if (bus1.rsp_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.cmd_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midrst_async: got v%b busy%b ready%b expected 000", bus1.rsp_valid, bus1.busy, bus1.cmd_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      vectors++;
      if (bus1.rsp_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.cmd_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL midrst_release: got v%b busy%b ready%b expected 001", bus1.rsp_valid, bus1.busy, bus1.cmd_ready);
      end
      bus1.rsp_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus1.rsp_valid === 1'b1) stale++;
      end
      vectors++;
      if (stale != 0) begin
         miscompares++;
         $display("[TB] FAIL midrst_stale: got %0d responses expected 0", stale);
      end
      bus1.rsp_ready = 1'b0;
   endtask

   task automatic test_alu_lat3();
      logic [7:0] res_tab [3] = '{8'h11, 8'h22, 8'h33};
      logic [3:0] flg_tab [3] = '{4'b0110, 4'b0110, 4'b1001};
      @(negedge clk);
      bus3.cmd_valid = 1'b1;
      bus3.cmd_op    = OP_XOR;
      bus3.cmd_a     = 8'h3C;
      bus3.cmd_b     = 8'h5A;
      @(posedge clk);
      #1 bus3.cmd_valid = 1'b0;
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         bus3.alu_result = res_tab[n];
         {bus3.alu_carry, bus3.alu_overflow, bus3.alu_zero, bus3.alu_negative} = flg_tab[n];
         vectors++;
         if (bus3.rsp_valid !== 1'b0 || {bus3.alu_select, bus3.alu_a, bus3.alu_b} !== {OP_XOR, 8'h3C, 8'h5A}) begin
            miscompares++;
            $display("[TB] FAIL lat3_hold[%0d]: got v%b alu %h expected v0 %h", n, bus3.rsp_valid, {bus3.alu_select, bus3.alu_a, bus3.alu_b}, {OP_XOR, 8'h3C, 8'h5A});
         end
      end
      @(negedge clk);
      bus3.alu_result = 8'hEE;
      vectors++;
      if (bus3.rsp_valid !== 1'b1 || bus3.rsp_result !== 8'h33 || bus3.rsp_flags !== 4'b1001) begin
         miscompares++;
         $display("[TB] FAIL lat3_capture: got v%b r%h f%b expected v1 r33 f1001", bus3.rsp_valid, bus3.rsp_result, bus3.rsp_flags);
      end
      bus3.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus3.rsp_ready = 1'b0;
   endtask

   // Scenario sequence.
   initial begin
      bus1.cmd_valid = 1'b0;
      bus1.cmd_a     = 8'h00;
      bus1.cmd_b     = 8'h00;
      bus1.cmd_op    = 4'h0;
      bus1.rsp_ready = 1'b0;
      bus3.cmd_valid = 1'b0;
      bus3.cmd_a     = 8'h00;
      bus3.cmd_b     = 8'h00;
      bus3.cmd_op    = 4'h0;
      bus3.rsp_ready = 1'b0;
      bus3.alu_result   = 8'h00;
      bus3.alu_carry    = 1'b0;
      bus3.alu_overflow = 1'b0;
      bus3.alu_zero     = 1'b0;
      bus3.alu_negative = 1'b0;
      test_reset();
      test_single("add", OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101);
      test_single("sub", OP_SUB, 8'h05, 8'h05, 8'h00, 4'b0010);
      test_single("and", OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000);
      test_single("div0", OP_DIV, 8'h10, 8'h00, 8'h00, 4'b0010);
      test_illegal_op();
      test_backpressure();
      test_reset_mid();
      test_alu_lat3();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Requester-side front end for the 8-bit combinational ALU.
- Accepts ALU commands (operands + 4-bit select) on a valid/ready input channel and buffers them in a small FIFO.
- Drives one command at a time onto registered ALU operand/select outputs, waits ALU_LAT cycles, then captures result and the four flags.
- Returns the captured result and flags on a valid/ready response channel; sits between a command source (test sequencer/CPU stub) and the ALU.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
ALU_LAT, 1, cycles operands are held stable before result/flags are sampled (>=1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_a  in  8  operand a
cmd_b  in  8  operand b
cmd_op  in  4  ALU select code
alu_a  out  8  registered operand a to ALU
alu_b  out  8  registered operand b to ALU
alu_select  out  4  registered select to ALU
alu_result  in  8  ALU result
alu_carry  in  1  ALU carry flag
alu_overflow  in  1  ALU overflow flag
alu_zero  in  1  ALU zero flag
alu_negative  in  1  ALU negative flag
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_result  out  8  captured result
rsp_flags  out  4  {carry,overflow,zero,negative}
rsp_err  out  1  illegal opcode (see Optional Feature)
busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- Clock/reset: one clock, clk; reset_n asynchronous active-low.
- Reset: FIFO empty; state IDLE; alu_a/alu_b/alu_select=0; rsp_valid=0; rsp_result=0; rsp_flags=0; rsp_err=0; busy=0; cmd_ready=0 while reset_n low.
- Command channel:
  - cmd_ready = !full (reset deasserted).
  - Push on cmd_valid&cmd_ready.
  - No push when full, even if a pop occurs the same cycle.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO non-empty, pop head into alu_a/alu_b/alu_select, clear wait counter, go EXEC.
  - EXEC: alu_* held stable; counter increments each cycle. On the edge where counter==ALU_LAT-1, capture alu_result and {alu_carry,alu_overflow,alu_zero,alu_negative} into rsp_result/rsp_flags; set rsp_valid; go RESP.
  - RESP: rsp_* held stable while rsp_valid&!rsp_ready. On handshake, clear rsp_valid; if FIFO non-empty, pop and go EXEC in the same edge, else go IDLE.
- Latency (ALU_LAT=1):
  - Command accepted at edge T into an empty idle block: popped at T+1; rsp_valid high after edge T+2.
  - Back-to-back throughput: one response per ALU_LAT+1 cycles with rsp_ready held high.
- Ordering: responses in strict command order. No command is dropped or duplicated.
- alu_* outputs keep the last issued command after completion; they change only on pop.
- Simultaneous push to empty FIFO and IDLE: entry written, popped the following cycle (no bypass).
- FIFO pointers: log2(DEPTH) bits plus wrap bit. Full/empty derived from pointer compare; wrap-around is transparent.
- Reset mid-operation: in-flight command, pending response and FIFO contents are discarded immediately (asynchronous).

Optional Feature:
- Macro: ALU_CMD_ISSUER_OPCHK_EN.
- Defined:
  - Popped opcodes > 4'b1010 are not driven to the ALU; alu_* are left unchanged.
  - FSM goes directly to RESP next edge with rsp_result=0, rsp_flags=0, rsp_err=1.
  - Legal opcodes give rsp_err=0.
- Undefined: all opcodes are forwarded to the ALU and its outputs are captured; rsp_err tied 0.

Decomposition:
- Package alu_issuer_pkg:
  - opcode localparams OP_ADD=0 … OP_NOT=4'hA and OP_MAX=4'hA;
  - FSM state encoding;
  - flag bit indices FLG_C=3, FLG_V=2, FLG_Z=1, FLG_N=0.
- Sub-module alu_cmd_fifo: 20-bit wide, DEPTH deep synchronous FIFO with push/pop/full/empty and the same async reset.

Test Plan:
- ADD a=8'h7F b=8'h01, ALU model attached -> rsp_result=8'h80, rsp_flags=4'b0101, rsp_valid after 3 cycles from accept.
- SUB a=8'h05 b=8'h05 -> rsp_result=8'h00, rsp_flags=4'b0010; DIV a=8'h10 b=8'h00 -> rsp_result=8'h00, rsp_flags=4'b0010.
- Backpressure, DEPTH=4, rsp_ready=0, cmd_valid held:
  - exactly 5 commands accepted (1 in RESP + 4 queued), then cmd_ready=0;
  - releasing rsp_ready returns all 5 in order with no gaps beyond ALU_LAT+1.
- reset_n pulsed low while in RESP with 3 queued -> rsp_valid=0, busy=0, cmd_ready=1 after release; no stale responses emitted.
- ALU_LAT=3: alu_a/alu_b/alu_select stable for exactly 3 cycles before capture; result is taken from the last cycle.
- op=4'b1100:
  - with ALU_CMD_ISSUER_OPCHK_EN -> rsp_err=1, result 8'h00, flags 4'b0000, alu_select unchanged;
  - without -> rsp_err=0, result 8'h00, flags 4'b0010.
